// File: rtl/lsu_mem_master.sv
// rtl/lsu_mem_master.sv - load/store initiator between the MEM stage and word-addressed data memory
//
// Purpose:
//   Accepts one load/store request at a time and turns it into one or two
//   word-aligned memory accesses with byte enables. Load data is merged,
//   shifted and sign/zero-extended, then returned on a valid/ready response.
//
// Optional feature (macro MISALIGN_SPLIT_EN):
//   defined     - a word-crossing access becomes two accesses (ACC_LO, ACC_HI);
//                 resp_fault is tied 0.
//   not defined - a misaligned half/word goes straight to RESP with
//                 resp_fault=1 and resp_rdata=0, and memory is not touched.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req_valid/req_ready       request handshake
//   req_we                    1 = store, 0 = load
//   req_store, req_load       store size (SW/SH/SB), load kind (LW/LH/LB/LHU/LBU)
//   req_addr, req_wdata       byte address, store data
//   resp_valid/resp_ready     response handshake
//   resp_rdata, resp_fault    extended load data, misalignment fault
//   mem_we, mem_be            write strobe and byte-lane enables
//   mem_addr, mem_wd          word address and lane-shifted write data
//   mem_rd                    combinational read data for mem_addr

module lsu_mem_master #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_store,
  input  logic [2:0]        req_load,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_fault,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wd,
  input  logic [31:0]       mem_rd
);

  typedef enum logic [1:0] {IDLE, ACC_LO, ACC_HI, RESP} state_t;

  state_t state, state_nx;

  // captured request
  logic              we_q;
  logic [2:0]        size_q;   // access size in bytes: 1, 2 or 4
  logic              sext_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;

  logic [31:0]       lo_q;     // low word of a split load
  logic [31:0]       rdata_q;

  logic [2:0]        req_size;
  logic              req_sext;

  logic [ADDR_W-1:0] word_lo;
  logic [ADDR_W-1:0] word_hi;
  logic [3:0]        be_mask;
  logic [7:0]        be_wide;
  logic [63:0]       wd_wide;
  logic [31:0]       merge_lo;
  logic [31:0]       merge_hi;
  logic [31:0]       merged;
  logic [31:0]       load_ext;
  logic              acc_cycle;

  // Request decode; unused encodings fall back to full word.
  always_comb begin
    req_size = 3'd4;
    req_sext = 1'b0;
    if (req_we) begin
      case (req_store)
        2'b01:   req_size = 3'd2;
        2'b10:   req_size = 3'd1;
        default: req_size = 3'd4;
      endcase
    end else begin
      case (req_load)
        3'b001:  begin req_size = 3'd2; req_sext = 1'b1; end
        3'b010:  begin req_size = 3'd1; req_sext = 1'b1; end
        3'b011:  req_size = 3'd2;
        3'b100:  req_size = 3'd1;
        default: req_size = 3'd4;
      endcase
    end
  end

`ifdef MISALIGN_SPLIT_EN
  logic crossing;
  assign crossing = ({1'b0, addr_q[1:0]} + size_q) > 3'd4;
`else
  logic req_misaligned;
  logic fault_q;
  assign req_misaligned = ((req_size == 3'd2) && req_addr[0]) ||
                          ((req_size == 3'd4) && (req_addr[1:0] != 2'b00));
`endif

  // Lane placement: the 8-bit/64-bit views span LO (low half) and HI (high half).
  assign word_lo = {addr_q[ADDR_W-1:2], 2'b00};
  assign word_hi = word_lo + ADDR_W'(4);   // wraps at the top of the address space

  always_comb begin
    case (size_q)
      3'd1:    be_mask = 4'b0001;
      3'd2:    be_mask = 4'b0011;
      default: be_mask = 4'b1111;
    endcase
    be_wide = {4'h0, be_mask} << addr_q[1:0];
    wd_wide = {32'h0, wdata_q} << {addr_q[1:0], 3'b000};
  end

  // Load merge: in ACC_HI the low word comes from lo_q and mem_rd is the high word.
  always_comb begin
    merge_lo = mem_rd;
    merge_hi = 32'h0;
    if (state == ACC_HI) begin
      merge_lo = lo_q;
      merge_hi = mem_rd;
    end
    merged = 32'({merge_hi, merge_lo} >> {addr_q[1:0], 3'b000});
    case (size_q)
      3'd1:    load_ext = sext_q ? {{24{merged[7]}}, merged[7:0]}
                                 : {24'h0, merged[7:0]};
      3'd2:    load_ext = sext_q ? {{16{merged[15]}}, merged[15:0]}
                                 : {16'h0, merged[15:0]};
      default: load_ext = merged;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
`ifdef MISALIGN_SPLIT_EN
          state_nx = ACC_LO;
`else
          state_nx = req_misaligned ? RESP : ACC_LO;
`endif
        end
      end
      ACC_LO: begin
`ifdef MISALIGN_SPLIT_EN
        state_nx = crossing ? ACC_HI : RESP;
`else
        state_nx = RESP;
`endif
      end
      ACC_HI:  state_nx = RESP;
      RESP:    state_nx = resp_ready ? IDLE : RESP;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs
  assign acc_cycle  = (state == ACC_LO) || (state == ACC_HI);
  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign resp_rdata = rdata_q;
  assign mem_we     = we_q && acc_cycle;
  assign mem_addr   = (state == ACC_HI) ? word_hi : word_lo;
  assign mem_be     = !mem_we ? 4'h0 : ((state == ACC_HI) ? be_wide[7:4] : be_wide[3:0]);
  assign mem_wd     = (state == ACC_HI) ? wd_wide[63:32] : wd_wide[31:0];
`ifdef MISALIGN_SPLIT_EN
  assign resp_fault = 1'b0;
`else
  assign resp_fault = fault_q;
`endif

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      size_q  <= 3'd4;
      sext_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      lo_q    <= 32'h0;
      rdata_q <= 32'h0;
`ifndef MISALIGN_SPLIT_EN
      fault_q <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            size_q  <= req_size;
            sext_q  <= req_sext;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            rdata_q <= 32'h0;
`ifndef MISALIGN_SPLIT_EN
            fault_q <= req_misaligned;
`endif
          end
        end
        ACC_LO: begin
          lo_q <= mem_rd;
          if (state_nx == RESP) rdata_q <= we_q ? 32'h0 : load_ext;
        end
        ACC_HI: rdata_q <= we_q ? 32'h0 : load_ext;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// tb/tb_lsu_mem_master.sv - self-checking bench for lsu_mem_master with a byte-lane memory model

module tb_lsu_mem_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_store;
  logic [2:0]  req_load;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  always #5 clk = ~clk;

  lsu_mem_master #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_store(req_store), .req_load(req_load), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  // 256-word memory: 0x100 -> 64, 0x104 -> 65, 0xFFFFFFFC -> 255, 0x0 -> 0
  logic [31:0] mem [0:255];
  assign mem_rd = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++)
        if (mem_be[i]) mem[mem_addr[9:2]][8*i +: 8] <= mem_wd[8*i +: 8];
    end
  end

  typedef struct packed {
    logic [31:0] rdata;
    logic        fault;
  } resp_t;

  resp_t sb[$];
  resp_t exp_r;
  int    n_tests = 0;
  int    n_fail  = 0;

  // Drive one request from a negedge in IDLE; returns at the negedge of cycle N+1.
  task automatic drive_req(input logic we, input logic [1:0] st, input logic [2:0] ld,
                           input logic [31:0] a, input logic [31:0] wd);
    req_valid = 1'b1;
    req_we    = we;
    req_store = st;
    req_load  = ld;
    req_addr  = a;
    req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({req_ready, resp_valid, resp_fault, mem_we, mem_be, resp_rdata} !== {1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_state: got ready=%b valid=%b fault=%b we=%b be=%b rdata=%h, want 1 0 0 0 0000 00000000",
               req_ready, resp_valid, resp_fault, mem_we, mem_be, resp_rdata);
    end
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({req_ready, resp_valid, mem_we} !== 3'b100) begin
      n_fail++;
      $display("FAIL post_reset_idle: got ready=%b valid=%b we=%b, want 1 0 0", req_ready, resp_valid, mem_we);
    end
  endtask

  task automatic test_store_byte;
    mem[64] = 32'h0;
    sb.push_back(resp_t'{rdata: 32'h0, fault: 1'b0});
    drive_req(1'b1, 2'b10, 3'b000, 32'h103, 32'h12345678);
    n_tests++;
    if ({mem_we, mem_addr, mem_be, mem_wd[31:24], resp_valid} !== {1'b1, 32'h100, 4'b1000, 8'h78, 1'b0}) begin
      n_fail++;
      $display("FAIL sb_access: got we=%b addr=%h be=%b wd3=%h valid=%b, want 1 00000100 1000 78 0",
               mem_we, mem_addr, mem_be, mem_wd[31:24], resp_valid);
    end
    @(negedge clk);
    n_tests++;
    if ({resp_valid, mem_we, mem_be} !== {1'b1, 1'b0, 4'h0}) begin
      n_fail++;
      $display("FAIL sb_latency: got valid=%b we=%b be=%b, want 1 0 0000", resp_valid, mem_we, mem_be);
    end
    exp_r = sb.pop_front();
    n_tests++;
    if ({resp_rdata, resp_fault} !== exp_r) begin
      n_fail++;
      $display("FAIL sb_resp: got rdata=%h fault=%b, want rdata=%h fault=%b", resp_rdata, resp_fault, exp_r.rdata, exp_r.fault);
    end
    n_tests++;
    if (mem[64] !== 32'h78000000) begin
      n_fail++;
      $display("FAIL sb_mem: got %h, want 78000000", mem[64]);
    end
    @(negedge clk);
  endtask

  logic [2:0]  lv_ld   [0:7] = '{3'b001, 3'b011, 3'b010, 3'b100, 3'b000, 3'b111, 3'b010, 3'b001};
  logic [31:0] lv_addr [0:7] = '{32'h102, 32'h102, 32'h103, 32'h103, 32'h100, 32'h100, 32'h102, 32'h100};
  logic [31:0] lv_exp  [0:7] = '{32'hFFFF8001, 32'h00008001, 32'hFFFFFF80, 32'h00000080,
                                 32'h80010000, 32'h80010000, 32'h00000001, 32'h00000000};

  task automatic test_load_ext;
    mem[64] = 32'h80010000;
    for (int i = 0; i < 8; i++) begin
      sb.push_back(resp_t'{rdata: lv_exp[i], fault: 1'b0});
      drive_req(1'b0, 2'b00, lv_ld[i], lv_addr[i], 32'hFFFFFFFF);
      n_tests++;
      if ({mem_we, mem_be, mem_addr, resp_valid} !== {1'b0, 4'h0, 32'h100, 1'b0}) begin
        n_fail++;
        $display("FAIL load_access[%0d]: got we=%b be=%b addr=%h valid=%b, want 0 0000 00000100 0",
                 i, mem_we, mem_be, mem_addr, resp_valid);
      end
      @(negedge clk);
      exp_r = sb.pop_front();
      n_tests++;
      if ({resp_valid, resp_rdata, resp_fault} !== {1'b1, exp_r}) begin
        n_fail++;
        $display("FAIL load_ext[%0d]: got valid=%b rdata=%h fault=%b, want 1 %h %b",
                 i, resp_valid, resp_rdata, resp_fault, exp_r.rdata, exp_r.fault);
      end
      @(negedge clk);
    end
  endtask

  logic [1:0]  sv_st   [0:2] = '{2'b01, 2'b11, 2'b10};
  logic [31:0] sv_addr [0:2] = '{32'h102, 32'h100, 32'h100};
  logic [31:0] sv_wd   [0:2] = '{32'h1234BEEF, 32'hCAFEF00D, 32'h9876545A};
  logic [3:0]  sv_be   [0:2] = '{4'b1100, 4'b1111, 4'b0001};
  logic [31:0] sv_lane [0:2] = '{32'hBEEF0000, 32'hCAFEF00D, 32'h0000005A};
  logic [31:0] sv_mem  [0:2] = '{32'hBEEF1111, 32'hCAFEF00D, 32'h1111115A};

  task automatic test_store_sizes;
    logic [31:0] mask;
    for (int i = 0; i < 3; i++) begin
      mem[64] = 32'h11111111;
      sb.push_back(resp_t'{rdata: 32'h0, fault: 1'b0});
      drive_req(1'b1, sv_st[i], 3'b000, sv_addr[i], sv_wd[i]);
      mask = 32'h0;
      for (int b = 0; b < 4; b++) if (sv_be[i][b]) mask[8*b +: 8] = 8'hFF;
      n_tests++;
      if ({mem_we, mem_be, mem_addr, mem_wd & mask} !== {1'b1, sv_be[i], 32'h100, sv_lane[i]}) begin
        n_fail++;
        $display("FAIL store_lanes[%0d]: got we=%b be=%b addr=%h wd=%h, want 1 %b 00000100 %h",
                 i, mem_we, mem_be, mem_addr, mem_wd & mask, sv_be[i], sv_lane[i]);
      end
      @(negedge clk);
      exp_r = sb.pop_front();
      n_tests++;
      if ({resp_valid, resp_rdata, resp_fault, mem[64]} !== {1'b1, exp_r, sv_mem[i]}) begin
        n_fail++;
        $display("FAIL store_result[%0d]: got valid=%b rdata=%h fault=%b mem=%h, want 1 %h %b %h",
                 i, resp_valid, resp_rdata, resp_fault, mem[64], exp_r.rdata, exp_r.fault, sv_mem[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_misaligned;
    mem[64] = 32'h44332211;
    mem[65] = 32'h88776655;
`ifdef MISALIGN_SPLIT_EN
    sb.push_back(resp_t'{rdata: 32'h55443322, fault: 1'b0});
    drive_req(1'b0, 2'b00, 3'b000, 32'h101, 32'h0);
    n_tests++;
    if ({mem_we, mem_addr, resp_valid} !== {1'b0, 32'h100, 1'b0}) begin
      n_fail++;
      $display("FAIL lw_split_lo: got we=%b addr=%h valid=%b, want 0 00000100 0", mem_we, mem_addr, resp_valid);
    end
    @(negedge clk);
    n_tests++;
    if ({mem_we, mem_addr, resp_valid} !== {1'b0, 32'h104, 1'b0}) begin
      n_fail++;
      $display("FAIL lw_split_hi: got we=%b addr=%h valid=%b, want 0 00000104 0", mem_we, mem_addr, resp_valid);
    end
    @(negedge clk);
    exp_r = sb.pop_front();
    n_tests++;
    if ({resp_valid, resp_rdata, resp_fault} !== {1'b1, exp_r}) begin
      n_fail++;
      $display("FAIL lw_split_resp: got valid=%b rdata=%h fault=%b, want 1 %h %b",
               resp_valid, resp_rdata, resp_fault, exp_r.rdata, exp_r.fault);
    end
    @(negedge clk);
    sb.push_back(resp_t'{rdata: 32'h00003322, fault: 1'b0});
    drive_req(1'b0, 2'b00, 3'b001, 32'h101, 32'h0);
    @(negedge clk);
`else
    sb.push_back(resp_t'{rdata: 32'h0, fault: 1'b1});
    drive_req(1'b0, 2'b00, 3'b000, 32'h101, 32'h0);
    exp_r = sb.pop_front();
    n_tests++;
    if ({resp_valid, resp_rdata, resp_fault, mem_we} !== {1'b1, exp_r, 1'b0}) begin
      n_fail++;
      $display("FAIL lw_fault: got valid=%b rdata=%h fault=%b we=%b, want 1 %h %b 0",
               resp_valid, resp_rdata, resp_fault, mem_we, exp_r.rdata, exp_r.fault);
    end
    @(negedge clk);
    sb.push_back(resp_t'{rdata: 32'h0, fault: 1'b1});
    drive_req(1'b0, 2'b00, 3'b001, 32'h101, 32'h0);
`endif
    exp_r = sb.pop_front();
    n_tests++;
    if ({resp_valid, resp_rdata, resp_fault} !== {1'b1, exp_r}) begin
      n_fail++;
      $display("FAIL lh_odd_resp: got valid=%b rdata=%h fault=%b, want 1 %h %b",
               resp_valid, resp_rdata, resp_fault, exp_r.rdata, exp_r.fault);
    end
    @(negedge clk);
  endtask

  task automatic test_split_store;
    mem[64] = 32'h44332211;
    mem[65] = 32'h88776655;
`ifdef MISALIGN_SPLIT_EN
    sb.push_back(resp_t'{rdata: 32'h0, fault: 1'b0});
    drive_req(1'b1, 2'b00, 3'b000, 32'h103, 32'hDDCCBBAA);
    n_tests++;
    if ({mem_we, mem_addr, mem_be, mem_wd[31:24]} !== {1'b1, 32'h100, 4'b1000, 8'hAA}) begin
      n_fail++;
      $display("FAIL sw_split_lo: got we=%b addr=%h be=%b wd3=%h, want 1 00000100 1000 aa",
               mem_we, mem_addr, mem_be, mem_wd[31:24]);
    end
    @(negedge clk);
    n_tests++;
    if ({mem_we, mem_addr, mem_be, mem_wd[23:0], resp_valid} !== {1'b1, 32'h104, 4'b0111, 24'hDDCCBB, 1'b0}) begin
      n_fail++;
      $display("FAIL sw_split_hi: got we=%b addr=%h be=%b wd=%h valid=%b, want 1 00000104 0111 ddccbb 0",
               mem_we, mem_addr, mem_be, mem_wd[23:0], resp_valid);
    end
    @(negedge clk);
    exp_r = sb.pop_front();
    n_tests++;
    if ({resp_valid, resp_rdata, resp_fault, mem[64], mem[65]} !== {1'b1, exp_r, 32'hAA332211, 32'h88DDCCBB}) begin
      n_fail++;
      $display("FAIL sw_split_result: got valid=%b rdata=%h fault=%b m0=%h m1=%h, want 1 %h %b aa332211 88ddccbb",
               resp_valid, resp_rdata, resp_fault, mem[64], mem[65], exp_r.rdata, exp_r.fault);
    end
`else
    sb.push_back(resp_t'{rdata: 32'h0, fault: 1'b1});
    drive_req(1'b1, 2'b00, 3'b000, 32'h103, 32'hDDCCBBAA);
    exp_r = sb.pop_front();
    n_tests++;
    if ({resp_valid, resp_rdata, resp_fault, mem_we} !== {1'b1, exp_r, 1'b0}) begin
      n_fail++;
      $display("FAIL sw_fault: got valid=%b rdata=%h fault=%b we=%b, want 1 %h %b 0",
               resp_valid, resp_rdata, resp_fault, mem_we, exp_r.rdata, exp_r.fault);
    end
    @(negedge clk);
    n_tests++;
    if ({mem[64], mem[65]} !== {32'h44332211, 32'h88776655}) begin
      n_fail++;
      $display("FAIL sw_fault_mem: got m0=%h m1=%h, want 44332211 88776655", mem[64], mem[65]);
    end
`endif
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    mem[64] = 32'h0BADF00D;
    resp_ready = 1'b0;
    sb.push_back(resp_t'{rdata: 32'h0BADF00D, fault: 1'b0});
    drive_req(1'b0, 2'b00, 3'b000, 32'h100, 32'h0);
    @(negedge clk);
    exp_r = sb.pop_front();
    // a second request is offered the whole time the response is pending
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_load  = 3'b010;
    req_addr  = 32'h100;
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if ({resp_valid, resp_rdata, resp_fault, req_ready} !== {1'b1, exp_r, 1'b0}) begin
        n_fail++;
        $display("FAIL hold_resp[%0d]: got valid=%b rdata=%h fault=%b ready=%b, want 1 %h %b 0",
                 i, resp_valid, resp_rdata, resp_fault, req_ready, exp_r.rdata, exp_r.fault);
      end
      if (i < 3) @(negedge clk);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({req_ready, resp_valid, mem_we} !== 3'b100) begin
      n_fail++;
      $display("FAIL no_accept_in_resp: got ready=%b valid=%b we=%b, want 1 0 0", req_ready, resp_valid, mem_we);
    end
    req_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    mem[64] = 32'h44332211;
    mem[65] = 32'h88776655;
`ifdef MISALIGN_SPLIT_EN
    drive_req(1'b0, 2'b00, 3'b000, 32'h101, 32'h0);
    @(negedge clk);
`else
    drive_req(1'b0, 2'b00, 3'b000, 32'h100, 32'h0);
`endif
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_tests++;
    if ({req_ready, resp_valid, mem_we, mem_be, resp_rdata, resp_fault} !== {1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_abort: got ready=%b valid=%b we=%b be=%b rdata=%h fault=%b, want 1 0 0 0000 00000000 0",
               req_ready, resp_valid, mem_we, mem_be, resp_rdata, resp_fault);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_tests++;
      if ({resp_valid, mem_we} !== 2'b00) begin
        n_fail++;
        $display("FAIL reset_no_resp[%0d]: got valid=%b we=%b, want 0 0", i, resp_valid, mem_we);
      end
    end
  endtask

  task automatic test_wrap;
    mem[255] = 32'h22110000;
    mem[0]   = 32'h00004433;
`ifdef MISALIGN_SPLIT_EN
    sb.push_back(resp_t'{rdata: 32'h44332211, fault: 1'b0});
    drive_req(1'b0, 2'b00, 3'b000, 32'hFFFFFFFE, 32'h0);
    n_tests++;
    if (mem_addr !== 32'hFFFFFFFC) begin
      n_fail++;
      $display("FAIL wrap_lo_addr: got %h, want fffffffc", mem_addr);
    end
    @(negedge clk);
    n_tests++;
    if (mem_addr !== 32'h00000000) begin
      n_fail++;
      $display("FAIL wrap_hi_addr: got %h, want 00000000", mem_addr);
    end
    @(negedge clk);
`else
    sb.push_back(resp_t'{rdata: 32'h0, fault: 1'b1});
    drive_req(1'b0, 2'b00, 3'b000, 32'hFFFFFFFE, 32'h0);
`endif
    exp_r = sb.pop_front();
    n_tests++;
    if ({resp_valid, resp_rdata, resp_fault} !== {1'b1, exp_r}) begin
      n_fail++;
      $display("FAIL wrap_resp: got valid=%b rdata=%h fault=%b, want 1 %h %b",
               resp_valid, resp_rdata, resp_fault, exp_r.rdata, exp_r.fault);
    end
    @(negedge clk);
    sb.push_back(resp_t'{rdata: 32'h00002211, fault: 1'b0});
    drive_req(1'b0, 2'b00, 3'b001, 32'hFFFFFFFE, 32'h0);
    n_tests++;
    if ({mem_addr, resp_valid} !== {32'hFFFFFFFC, 1'b0}) begin
      n_fail++;
      $display("FAIL top_lh_addr: got addr=%h valid=%b, want fffffffc 0", mem_addr, resp_valid);
    end
    @(negedge clk);
    exp_r = sb.pop_front();
    n_tests++;
    if ({resp_valid, resp_rdata, resp_fault} !== {1'b1, exp_r}) begin
      n_fail++;
      $display("FAIL top_lh_resp: got valid=%b rdata=%h fault=%b, want 1 %h %b",
               resp_valid, resp_rdata, resp_fault, exp_r.rdata, exp_r.fault);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [31:0] word;
    logic [7:0]  b;
    logic        is_lb;
    int          cnt;
    word    = 32'hF1E2D3C4;
    mem[64] = word;
    for (int i = 0; i < 8; i++) begin
      is_lb = (i % 2) == 0;
      b     = 8'(word >> (8 * (i % 4)));
      sb.push_back(resp_t'{rdata: is_lb ? {{24{b[7]}}, b} : {24'h0, b}, fault: 1'b0});
      drive_req(1'b0, 2'b00, is_lb ? 3'b010 : 3'b100, 32'h100 + 32'(i % 4), 32'h0);
      cnt = 0;
      while (!resp_valid && cnt < 6) begin
        @(negedge clk);
        cnt++;
      end
      exp_r = sb.pop_front();
      n_tests++;
      if ({resp_valid, cnt, resp_rdata, resp_fault} !== {1'b1, 1, exp_r}) begin
        n_fail++;
        $display("FAIL b2b[%0d]: got valid=%b wait=%0d rdata=%h fault=%b, want 1 1 %h %b",
                 i, resp_valid, cnt, resp_rdata, resp_fault, exp_r.rdata, exp_r.fault);
      end
      @(negedge clk);
    end
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d entries left, want 0", sb.size());
    end
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_store  = 2'b00;
    req_load   = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    resp_ready = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    @(negedge clk);
    test_reset();
    test_store_byte();
    test_load_ext();
    test_store_sizes();
    test_misaligned();
    test_split_store();
    test_backpressure();
    test_reset_mid();
    test_wrap();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
